// File: rtl/asap_ctrl.sv
// Sequencer for the ASAP two-bus datapath: one job per accepted start.
// It loads the operands, iterates F1/F2 a programmed number of times, then presents R1.
module asap_ctrl #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] iters,
  input  logic [3:0]           f1_sel,
  input  logic [1:0]           f2_sel,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic                 in0_oe,
  output logic                 in1_oe,
  output logic                 f1_oe,
  output logic                 f2_oe,
  output logic                 out_oe,
  output logic                 r2_sel,
  output logic                 r1_en,
  output logic                 r2_en,
  output logic                 r3_en,
  output logic [3:0]           f1_f,
  output logic [1:0]           f2_f
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    LOAD    = 4'b0010,
    COMPUTE = 4'b0100,
    OUT     = 4'b1000
  } state_t;

  state_t               state;
  state_t               nxt;
  logic [CNT_WIDTH-1:0] count;
  logic [10:0]          ctl;

  // Control vector order:
  // {busy, out_valid, in0_oe, in1_oe, f1_oe, f2_oe, out_oe, r2_sel, r1_en, r2_en, r3_en}
  function automatic logic [10:0] decode(input state_t s);
    logic [10:0] c;
    c = '0;
    case (s)
      LOAD:    c = 11'b101_1000_0111;
      COMPUTE: c = 11'b100_0110_0110;
      OUT:     c = 11'b110_0001_0000;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign {busy, out_valid, in0_oe, in1_oe, f1_oe, f2_oe,
          out_oe, r2_sel, r1_en, r2_en, r3_en} = ctl;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LOAD;
      LOAD:    nxt = (count != '0) ? COMPUTE : OUT;
      // A count of 0 cannot reach COMPUTE; treating it like 1 keeps the FSM from sticking.
      COMPUTE: if (count <= CNT_WIDTH'(1)) nxt = OUT;
      OUT:     if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      f1_f  <= '0;
      f2_f  <= '0;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt);
      if (state == IDLE && start) begin
        count <= iters;
        f1_f  <= f1_sel;
        f2_f  <= f2_sel;
      end else if (state == COMPUTE && count != '0) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_asap_ctrl.sv
// Directed bench for asap_ctrl, with a small behavioural datapath driven by its enables.
module tb_asap_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] iters;
  logic [3:0] f1_sel;
  logic [1:0] f2_sel;
  logic       out_ready;
  logic busy, out_valid, in0_oe, in1_oe, f1_oe, f2_oe, out_oe, r2_sel, r1_en, r2_en, r3_en;
  logic [3:0] f1_f;
  logic [1:0] f2_f;

  int total = 0;
  int bad   = 0;

  localparam logic [10:0] C_IDLE    = 11'b00000000000;
  localparam logic [10:0] C_LOAD    = 11'b10110000111;
  localparam logic [10:0] C_COMPUTE = 11'b10001100110;
  localparam logic [10:0] C_OUT     = 11'b11000010000;

  logic [10:0] ctl;
  assign ctl = {busy, out_valid, in0_oe, in1_oe, f1_oe, f2_oe, out_oe, r2_sel, r1_en, r2_en, r3_en};

  asap_ctrl #(.CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .iters(iters), .f1_sel(f1_sel), .f2_sel(f2_sel),
    .out_ready(out_ready), .busy(busy), .out_valid(out_valid), .in0_oe(in0_oe),
    .in1_oe(in1_oe), .f1_oe(f1_oe), .f2_oe(f2_oe), .out_oe(out_oe), .r2_sel(r2_sel),
    .r1_en(r1_en), .r2_en(r2_en), .r3_en(r3_en), .f1_f(f1_f), .f2_f(f2_f)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: F1 = R1 + R2 + f1_f, F2 = R2 + f2_f.
  logic [31:0] in0 = 32'h0000_00A5;
  logic [31:0] in1 = 32'h0000_0010;
  logic [31:0] r1, r2, r3, bus1, bus2, f1v, f2v, dout;

  always_comb begin
    f1v  = r1 + r2 + {28'd0, f1_f};
    f2v  = r2 + {30'd0, f2_f};
    bus1 = in0_oe ? in0 : (f1_oe ? f1v : 32'd0);
    bus2 = in1_oe ? in1 : (f2_oe ? f2v : 32'd0);
    dout = out_oe ? r1 : 32'd0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
    end else begin
      if (r1_en) r1 <= bus1;
      if (r2_en) r2 <= r2_sel ? bus1 : bus2;
      if (r3_en) r3 <= bus1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((in0_oe & f1_oe) | (in1_oe & f2_oe) | r2_sel | (out_valid & ~busy) |
          (out_oe & ~out_valid) | !$onehot(dut.state)) begin
        bad++;
        $display("FAIL invariant t=%0t ctl=%b state=%b", $time, ctl, dut.state);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] it, input logic [3:0] f1, input logic [1:0] f2);
    start = 1'b1; iters = it; f1_sel = f1; f2_sel = f2;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; iters = 0; f1_sel = 0; f2_sel = 0; out_ready = 0;
    #12;
    total++;
    if (ctl !== C_IDLE || f1_f !== 4'd0 || f2_f !== 2'd0) begin
      bad++; $display("FAIL reset_outputs got ctl=%b f1=%h f2=%h want all zero", ctl, f1_f, f2_f);
    end
    rst = 1'b0;
    tick();
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL reset_idle got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_iters0();
    out_ready = 1'b1;
    start_job(8'd0, 4'h1, 2'h0);
    total++;
    if (ctl !== C_LOAD) begin bad++; $display("FAIL i0_load got %b want %b", ctl, C_LOAD); end
    tick();
    total++;
    if (ctl !== C_OUT || dout !== 32'h0000_00A5) begin
      bad++; $display("FAIL i0_out got ctl=%b out=%h want %b 000000a5", ctl, dout, C_OUT);
    end
    tick();
    total++;
    if (ctl !== C_IDLE || r3 !== 32'h0000_00A5) begin
      bad++; $display("FAIL i0_idle got ctl=%b r3=%h want %b 000000a5", ctl, r3, C_IDLE);
    end
  endtask

  task automatic test_compute();
    out_ready = 1'b1;
    start_job(8'd3, 4'h2, 2'h1);
    total++;
    if (ctl !== C_LOAD) begin bad++; $display("FAIL cmp_load got %b want %b", ctl, C_LOAD); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      total++;
      if (ctl !== C_COMPUTE || f1_f !== 4'h2 || f2_f !== 2'h1) begin
        bad++;
        $display("FAIL cmp_cycle%0d got ctl=%b f1=%h f2=%h want %b 2 1", c, ctl, f1_f, f2_f, C_COMPUTE);
      end
    end
    tick();
    total++;
    if (ctl !== C_OUT || dout !== 32'h0000_00DE || r3 !== 32'h0000_00A5) begin
      bad++; $display("FAIL cmp_out got ctl=%b out=%h r3=%h want %b 000000de 000000a5", ctl, dout, r3, C_OUT);
    end
    tick();
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL cmp_idle got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_job(8'd1, 4'h0, 2'h0);
    tick();
    total++;
    if (ctl !== C_COMPUTE) begin bad++; $display("FAIL bp_compute got %b want %b", ctl, C_COMPUTE); end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ctl !== C_OUT) begin bad++; $display("FAIL bp_hold%0d got %b want %b", i, ctl, C_OUT); end
      tick();
    end
    out_ready = 1'b1;
    total++;
    if (ctl !== C_OUT) begin bad++; $display("FAIL bp_release got %b want %b", ctl, C_OUT); end
    tick();
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL bp_idle got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_ignore_start();
    int n;
    out_ready = 1'b0;
    start_job(8'd2, 4'h3, 2'h2);
    start = 1'b1; iters = 8'd9; f1_sel = 4'hF; f2_sel = 2'h0;
    total++;
    if (ctl !== C_LOAD || f1_f !== 4'h3) begin
      bad++; $display("FAIL ign_load got ctl=%b f1=%h want %b 3", ctl, f1_f, C_LOAD);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      total++;
      if (ctl !== C_COMPUTE || f1_f !== 4'h3 || f2_f !== 2'h2) begin
        bad++; $display("FAIL ign_cmp%0d got ctl=%b f1=%h f2=%h want %b 3 2", c, ctl, f1_f, f2_f, C_COMPUTE);
      end
    end
    tick();
    tick();
    total++;
    if (ctl !== C_OUT || f1_f !== 4'h3) begin
      bad++; $display("FAIL ign_out got ctl=%b f1=%h want %b 3", ctl, f1_f, C_OUT);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (ctl !== C_IDLE || f1_f !== 4'h3) begin
      bad++; $display("FAIL ign_idle got ctl=%b f1=%h want %b 3", ctl, f1_f, C_IDLE);
    end
    tick();
    start = 1'b0;
    total++;
    if (ctl !== C_LOAD || f1_f !== 4'hF || f2_f !== 2'h0) begin
      bad++; $display("FAIL b2b_load got ctl=%b f1=%h f2=%h want %b f 0", ctl, f1_f, f2_f, C_LOAD);
    end
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    total++;
    if (n !== 10) begin bad++; $display("FAIL b2b_latency got %0d want 10", n); end
    tick();
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b1;
    start_job(8'd5, 4'h1, 2'h1);
    tick(); tick(); tick();
    total++;
    if (ctl !== C_COMPUTE) begin bad++; $display("FAIL rmid_pre got %b want %b", ctl, C_COMPUTE); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (ctl !== C_IDLE || f1_f !== 4'h0 || f2_f !== 2'h0 || r1 !== 32'd0) begin
      bad++; $display("FAIL rmid_async got ctl=%b f1=%h f2=%h r1=%h want zero", ctl, f1_f, f2_f, r1);
    end
    rst = 1'b0;
    tick();
    start_job(8'd0, 4'h0, 2'h0);
    total++;
    if (ctl !== C_LOAD) begin bad++; $display("FAIL rmid_load got %b want %b", ctl, C_LOAD); end
    tick();
    total++;
    if (ctl !== C_OUT || dout !== 32'h0000_00A5) begin
      bad++; $display("FAIL rmid_out got ctl=%b out=%h want %b 000000a5", ctl, dout, C_OUT);
    end
    tick();
  endtask

  task automatic test_long();
    int n, comp;
    out_ready = 1'b1;
    start_job(8'd255, 4'h0, 2'h0);
    n = 1; comp = 0;
    while (!out_valid && n < 400) begin
      tick(); n++;
      if (f1_oe) comp++;
    end
    total++;
    if (n !== 257 || comp !== 255) begin
      bad++; $display("FAIL long_run got cycle=%0d compute=%0d want 257 255", n, comp);
    end
    tick();
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL long_idle got %b want %b", ctl, C_IDLE); end
  endtask

  initial begin
    test_reset();
    test_iters0();
    test_compute();
    test_backpressure();
    test_ignore_start();
    test_rst_mid();
    test_long();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
